// File: rtl/color_convert_sched_pkg.sv
// -----------------------------------------------------------------------------
// color_convert_sched_pkg
// Shared types and constants for the float-to-RGB color conversion path:
// pixel identifiers, float colors from pixel storage, packed 16-bit results
// and the entries written to the pixel buffer.
// -----------------------------------------------------------------------------
package color_convert_sched_pkg;

  // Cycles from the blue-channel strobe to the packed result on pl_color.
  localparam int CC_PL_DEPTH = 13;

  typedef logic [15:0] pixelID_t;

  // IEEE-754 single-precision bit patterns, one per channel.
  typedef struct packed {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
  } float_color_t;

  // 5-6-5 packed RGB produced by the datapath.
  typedef logic [15:0] color16_t;

  typedef struct packed {
    pixelID_t     pixelID;
    float_color_t color;
  } pixstore_to_cc_t;

  typedef struct packed {
    pixelID_t pixelID;
    color16_t color16;
  } pixel_buffer_entry_t;

endpackage

// File: rtl/color_convert_sched_fifo.sv
// -----------------------------------------------------------------------------
// color_convert_sched_fifo
// Synchronous single-clock FIFO used as the output buffer toward the pixel
// buffer. Head data is presented whenever rd_valid_o is high and stays stable
// until it is popped (rd_en_i while rd_valid_o).
//
// Ports:
//   clk, rst    clock, synchronous active-high reset (empties the FIFO)
//   wr_en_i     push wr_data_i this cycle (caller guarantees not full)
//   wr_data_i   entry to push
//   rd_en_i     consumer ready; pops the head when rd_valid_o is high
//   rd_valid_o  head entry valid (registered)
//   rd_data_o   head entry
// -----------------------------------------------------------------------------
module color_convert_sched_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             not_empty_q;
  logic             push;
  logic             pop;
  logic             full;

  assign push = wr_en_i;
  assign pop  = rd_en_i && not_empty_q;
  assign full = (count_q == CW'(DEPTH));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      not_empty_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      not_empty_q <= (count_d != '0);
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which
  // slots are meaningful, and leaving the array unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_valid_o = not_empty_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  // The producer reserves space before issuing work, so a push into a full
  // buffer means the credit accounting is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/color_convert_sched.sv
// -----------------------------------------------------------------------------
// color_convert_sched
// Sequencer and flow controller for the shared float-to-RGB conversion
// datapath. Accepts one pixel at a time, steps the red/green/blue strobes
// through the single datapath, carries each pixel ID alongside the datapath
// latency, and buffers {pixelID, color16} results in a credit-managed FIFO so
// nothing is dropped while the pixel buffer stalls.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   us_valid     pixel-store entry valid
//   us_data      pixelID and float color
//   us_stall     upstream stall (combinational, only while us_valid)
//   pl_color_fp  float color held for the datapath
//   v0, v1, v2   red, green, blue channel strobes
//   pl_color     packed result from the datapath
//   ds_valid     pixel-buffer entry valid
//   ds_data      {pixelID, color16}
//   ds_stall     pixel-buffer stall
// -----------------------------------------------------------------------------
module color_convert_sched
  import color_convert_sched_pkg::*;
#(
  parameter int PL_DEPTH   = CC_PL_DEPTH,
  // Must be at least PL_DEPTH/3 + 2 to sustain one pixel per three cycles.
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                us_valid,
  input  pixstore_to_cc_t     us_data,
  output logic                us_stall,
  output float_color_t        pl_color_fp,
  output logic                v0,
  output logic                v1,
  output logic                v2,
  input  color16_t            pl_color,
  output logic                ds_valid,
  output pixel_buffer_entry_t ds_data,
  input  logic                ds_stall
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RED  = 2'd1;
  localparam logic [1:0] S_GRN  = 2'd2;
  localparam logic [1:0] S_BLU  = 2'd3;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [CW-1:0]       credit_q;
  logic [CW-1:0]       credit_d;
  logic                accept;
  logic                pop;
  float_color_t        color_q;
  pixelID_t            id_q;
  logic                v0_q;
  logic                v1_q;
  logic                v2_q;
  logic [PL_DEPTH-1:0] tag_vld_q;
  pixelID_t            tag_id_q [PL_DEPTH];
  logic                fifo_wr;
  pixel_buffer_entry_t fifo_wr_data;

  // A new pixel may start when the datapath is free (IDLE) or finishing its
  // last channel (BLU), and only if an output slot can be reserved for it.
  assign accept   = us_valid && ((state_q == S_IDLE) || (state_q == S_BLU)) &&
                    (credit_q != '0);
  assign us_stall = us_valid && !accept;
  assign pop      = ds_valid && !ds_stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RED:   state_d = S_GRN;
      S_GRN:   state_d = S_BLU;
      default: state_d = accept ? S_RED : S_IDLE;
    endcase
  end

  // Credit = FIFO slots neither occupied nor reserved by in-flight pixels.
  always_comb begin
    credit_d = credit_q;
    case ({accept, pop})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  // Strobes are decoded from the next state so they leave a flop directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= CW'(FIFO_DEPTH);
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      v0_q     <= (state_d == S_RED);
      v1_q     <= (state_d == S_GRN);
      v2_q     <= (state_d == S_BLU);
    end
  end

  // Color and ID are captured on accept and held through all three channels;
  // an accept in the BLU cycle updates them only after that cycle completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_q <= '0;
      id_q    <= '0;
    end else if (accept) begin
      color_q <= us_data.color;
      id_q    <= us_data.pixelID;
    end
  end

  // Tag line: tracks which datapath result belongs to which pixel. It never
  // stalls because the datapath never stalls; only valid bits need clearing
  // so stale datapath results are ignored after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[PL_DEPTH-2:0], (state_q == S_BLU)};
    end
  end

  always_ff @(posedge clk) begin
    tag_id_q[0] <= id_q;
    for (int i = 1; i < PL_DEPTH; i++) begin
      tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  assign fifo_wr              = tag_vld_q[PL_DEPTH-1];
  assign fifo_wr_data.pixelID = tag_id_q[PL_DEPTH-1];
  assign fifo_wr_data.color16 = pl_color;

  color_convert_sched_fifo #(
    .WIDTH ($bits(pixel_buffer_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (fifo_wr),
    .wr_data_i  (fifo_wr_data),
    .rd_en_i    (!ds_stall),
    .rd_valid_o (ds_valid),
    .rd_data_o  (ds_data)
  );

  assign pl_color_fp = color_q;
  assign v0          = v0_q;
  assign v1          = v1_q;
  assign v2          = v2_q;

  a_credit_range: assert property (@(posedge clk) disable iff (rst)
                                   credit_q <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_color_convert_sched.sv
// -----------------------------------------------------------------------------
// tb_color_convert_sched
// Directed bench for color_convert_sched. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A small datapath model
// returns a packed color PL_DEPTH cycles after each blue strobe, and a
// scoreboard checks pixel-buffer entries in acceptance order.
// -----------------------------------------------------------------------------
module tb_color_convert_sched;
  import color_convert_sched_pkg::*;

  localparam int PL_DEPTH   = CC_PL_DEPTH;
  localparam int FIFO_DEPTH = 16;
  localparam int LIMIT      = 300;

  logic                clk = 1'b0;
  logic                rst;
  logic                us_valid;
  pixstore_to_cc_t     us_data;
  logic                us_stall;
  float_color_t        pl_color_fp;
  logic                v0;
  logic                v1;
  logic                v2;
  color16_t            pl_color;
  logic                ds_valid;
  pixel_buffer_entry_t ds_data;
  logic                ds_stall;

  always #5 clk = ~clk;

  color_convert_sched #(
    .PL_DEPTH   (PL_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .us_valid    (us_valid),
    .us_data     (us_data),
    .us_stall    (us_stall),
    .pl_color_fp (pl_color_fp),
    .v0          (v0),
    .v1          (v1),
    .v2          (v2),
    .pl_color    (pl_color),
    .ds_valid    (ds_valid),
    .ds_data     (ds_data),
    .ds_stall    (ds_stall)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Datapath model: packed color as a simple function of the float bits.
  function automatic color16_t model_color(input float_color_t c);
    return c.r[15:0] ^ c.g[15:0] ^ c.b[15:0];
  endfunction

  function automatic pixstore_to_cc_t mk_pix(input pixelID_t id);
    pixstore_to_cc_t p;
    p.pixelID = id;
    p.color.r = {16'h3F80, 16'(id * 16'h0101)};
    p.color.g = {16'h4000, id ^ 16'h5A5A};
    p.color.b = {16'h0000, ~id};
    return p;
  endfunction

  // ---------------- datapath model ----------------
  int       dp_t_q[$];
  color16_t dp_c_q[$];

  always @(negedge clk) begin
    pl_color = 16'hDEAD;
    if (dp_t_q.size() > 0 && dp_t_q[0] == cyc) begin
      pl_color = dp_c_q.pop_front();
      void'(dp_t_q.pop_front());
    end
    if (v2) begin
      dp_t_q.push_back(cyc + PL_DEPTH);
      dp_c_q.push_back(model_color(pl_color_fp));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  pixel_buffer_entry_t exp_q[$];
  int                  acc_cyc_q[$];
  int                  acc_cnt    = 0;
  int                  pop_cnt    = 0;
  int                  stall_cnt  = 0;
  int                  onehot_bad = 0;
  int                  hold_bad   = 0;
  int                  stall_bad  = 0;
  logic                prev_hold  = 1'b0;
  pixel_buffer_entry_t prev_data;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (us_valid && !us_stall) begin
        exp_q.push_back('{pixelID: us_data.pixelID, color16: model_color(us_data.color)});
        acc_cyc_q.push_back(cyc);
        acc_cnt++;
      end
      if (us_stall) stall_cnt++;
      if (us_stall && !us_valid) stall_bad++;
      if (int'(v0) + int'(v1) + int'(v2) > 1) onehot_bad++;
      if (prev_hold && (!ds_valid || ds_data != prev_data)) hold_bad++;
      prev_hold = ds_valid && ds_stall;
      prev_data = ds_data;
      if (ds_valid && !ds_stall) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("ds_unexpected", exp_q.size(), 1);
        else                   check("ds_order", ds_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_pixel(input pixstore_to_cc_t p, output int acc_at);
    int n;
    n = 0;
    @(posedge clk); #1;
    us_valid = 1'b1;
    us_data  = p;
    @(negedge clk);
    while (us_stall && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("send_wait", n < LIMIT, 1'b1);
    acc_at = cyc;
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    us_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  int ta, tv0, tv1, tv2, ds_first, ds_cnt, v_cnt, cnt, n, ibad, a0, p0, tb_acc;
  pixel_buffer_entry_t got_entry;

  initial begin
    rst      = 1'b1;
    us_valid = 1'b0;
    us_data  = '0;
    ds_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and idle upstream
    @(negedge clk);
    check("rst_v0", v0, 1'b0);
    check("rst_v1", v1, 1'b0);
    check("rst_v2", v2, 1'b0);
    check("rst_ds_valid", ds_valid, 1'b0);
    check("rst_us_stall", us_stall, 1'b0);
    check("rst_fp", pl_color_fp, 96'h0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (v0 || v1 || v2 || ds_valid || us_stall) cnt++;
    end
    check("idle_quiet", cnt, 0);

    // Single pixel
    send_pixel('{pixelID: 16'h00A5,
                 color: '{r: 32'h0000_F800, g: 32'h0000_0000, b: 32'h0000_001F}}, ta);
    idle_in();
    tv0 = -1; tv1 = -1; tv2 = -1; ds_first = -1; ds_cnt = 0; v_cnt = 0;
    got_entry = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) check("single_fp", pl_color_fp, {32'h0000_F800, 32'h0, 32'h0000_001F});
      if (v0) begin tv0 = cyc - ta; v_cnt++; end
      if (v1) begin tv1 = cyc - ta; v_cnt++; end
      if (v2) begin tv2 = cyc - ta; v_cnt++; end
      if (ds_valid) begin
        ds_cnt++;
        if (ds_first < 0) begin
          ds_first  = cyc - ta;
          got_entry = ds_data;
        end
      end
    end
    check("single_v0_at", tv0, 1);
    check("single_v1_at", tv1, 2);
    check("single_v2_at", tv2, 3);
    check("single_strobes", v_cnt, 3);
    check("single_ds_at", ds_first, 17);
    check("single_ds_cnt", ds_cnt, 1);
    check("single_ds_data", got_entry, 32'h00A5_F81F);

    // Streaming: 30 back-to-back pixels
    #1;
    stall_cnt = 0;
    acc_cyc_q.delete();
    a0 = acc_cnt;
    p0 = pop_cnt;
    for (int i = 0; i < 30; i++) send_pixel(mk_pix(16'h0100 + 16'(i)), ta);
    idle_in();
    check("stream_accepts", acc_cnt - a0, 30);
    check("stream_stalls", stall_cnt, 58);
    ibad = 0;
    for (int i = 1; i < acc_cyc_q.size(); i++)
      if (acc_cyc_q[i] - acc_cyc_q[i-1] != 3) ibad++;
    check("stream_gap", ibad, 0);
    drain("stream_drain");
    check("stream_pops", pop_cnt - p0, 30);

    // Reset mid-flight
    for (int i = 0; i < 3; i++) send_pixel(mk_pix(16'h0200 + 16'(i)), ta);
    idle_in();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_v", {v0, v1, v2}, 3'b000);
    check("mid_rst_ds_valid", ds_valid, 1'b0);
    check("mid_rst_fp", pl_color_fp, 96'h0);
    check("mid_rst_us_stall", us_stall, 1'b0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (ds_valid) cnt++;
    end
    check("mid_rst_no_output", cnt, 0);

    // Downstream backpressure (also shows credit restarted at FIFO_DEPTH)
    @(posedge clk); #1;
    ds_stall = 1'b1;
    a0 = acc_cnt;
    p0 = pop_cnt;
    fork
      begin
        for (int i = 0; i < 20; i++) send_pixel(mk_pix(16'h0300 + 16'(i)), tb_acc);
        idle_in();
      end
      begin
        repeat (90) @(negedge clk);
        #1;
        check("bp_accepts", acc_cnt - a0, FIFO_DEPTH);
        check("bp_us_stall", us_stall, 1'b1);
        check("bp_ds_valid", ds_valid, 1'b1);
        check("bp_no_pops", pop_cnt - p0, 0);
        @(posedge clk); #1;
        ds_stall = 1'b0;
      end
    join
    drain("bp_drain");
    check("bp_pops", pop_cnt - p0, 20);

    // Simultaneous accept and pop at credit = 1
    @(posedge clk); #1;
    ds_stall = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 15; i++) send_pixel(mk_pix(16'h0400 + 16'(i)), ta);
    idle_in();
    repeat (25) @(negedge clk);
    check("sim_fill_valid", ds_valid, 1'b1);
    @(posedge clk); #1;
    us_valid = 1'b1;
    us_data  = mk_pix(16'h04A0);
    ds_stall = 1'b0;
    @(negedge clk);
    ta = cyc;
    check("sim_a_accept", us_stall, 1'b0);
    check("sim_a_pop", ds_valid, 1'b1);
    @(posedge clk); #1;
    ds_stall = 1'b1;
    us_data  = mk_pix(16'h04B0);
    n = 0;
    @(negedge clk);
    while (us_stall && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("sim_b_gap", cyc - ta, 3);
    @(posedge clk); #1;
    us_data = mk_pix(16'h04C0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (!us_stall) cnt++;
    end
    check("sim_c_blocked", cnt, 0);
    @(posedge clk); #1;
    ds_stall = 1'b0;
    n = 0;
    @(negedge clk);
    while (us_stall && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("sim_c_accept", n < LIMIT, 1'b1);
    idle_in();
    drain("sim_drain");
    check("sim_pops", pop_cnt - p0, 18);

    // Run-long invariants
    check("strobe_onehot", onehot_bad, 0);
    check("ds_hold_stable", hold_bad, 0);
    check("stall_without_valid", stall_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/color_convert_sched.md
# color_convert_sched

Sequencer and flow controller for the shared float-to-RGB color conversion pipeline. It accepts one pixel (pixelID plus float color) at a time from pixel storage and drives the three channel strobes (red, green, blue) through the single multiplier/fp-to-int datapath. It tracks each pixel's ID alongside the pipeline latency and emits `{pixelID, color16}` entries to the pixel buffer through a credit-managed output FIFO, so results are never dropped when downstream stalls.

## Interface
Parameters:
- `PL_DEPTH`, 13, cycles from the v2 strobe of a pixel to its packed `color16_t` appearing on `pl_color`.
- `FIFO_DEPTH`, 16, output FIFO entries; must be at least `PL_DEPTH/3 + 2`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `us_valid`  in  1  pixel-store entry valid.
- `us_data`  in  `$bits(pixstore_to_cc_t)`  pixelID and float color.
- `us_stall`  out  1  upstream stall; asserted only while `us_valid`=1.
- `pl_color_fp`  out  `$bits(float_color_t)`  float color held for the datapath.
- `v0`, `v1`, `v2`  out  1 each  red, green and blue channel strobes to the datapath.
- `pl_color`  in  `$bits(color16_t)`  packed result from the datapath.
- `ds_valid`  out  1  pixel-buffer entry valid.
- `ds_data`  out  `$bits(pixel_buffer_entry_t)`  `{pixelID, color16}`.
- `ds_stall`  in  1  pixel-buffer stall.

## Operation
- FSM states:
  - IDLE: no strobe asserted.
  - RED: `v0`=1.
  - GRN: `v1`=1.
  - BLU: `v2`=1.
- Transitions:
  - RED→GRN→BLU are unconditional.
  - From IDLE or BLU: an accept moves the FSM to RED; otherwise it moves to IDLE.
- At most one of `v0`, `v1`, `v2` is high in any cycle.
- Accept condition: `us_valid` & (state ∈ {IDLE, BLU}) & (`credit` > 0).
- `us_stall` = `us_valid` & ~accept.
- On accept:
  - `us_data.color` is registered into `pl_color_fp`, which is held until the next accept.
  - `us_data.pixelID` is registered into the ID holding register.
- Tag line: a `PL_DEPTH`-stage shift register of `{valid, pixelID}`. It is loaded with `{1, held ID}` in the BLU cycle and with `{0, x}` otherwise, and shifts every cycle (never stalls).
- Tag exit: when the tag line output has valid=1, the block writes `{tag pixelID, pl_color}` into the FIFO in that cycle.
- `credit` counts FIFO free slots not already reserved by in-flight pixels. Reset value is `FIFO_DEPTH`.
  - Decrement on accept.
  - Increment on FIFO pop (`ds_valid` & ~`ds_stall`).
  - Accept and pop in the same cycle leave it unchanged.
  - Range is 0..`FIFO_DEPTH`.
- FIFO write when full is impossible by construction; the implementation carries an assertion for it.
- Reset values (all outputs and state):
  - FSM = IDLE.
  - `v0`=`v1`=`v2`=0.
  - `ds_valid`=0.
  - `us_stall`=0 while `us_valid`=0.
  - `pl_color_fp`=0.
  - All tag valid bits = 0.
  - FIFO empty.
  - `credit`=`FIFO_DEPTH`.
- Reset mid-operation: in-flight pixels and FIFO contents are discarded. Datapath results arriving after reset are ignored, because their tags have been cleared.

## Timing
- Accept in cycle t → RED (`v0`) at t+1, GRN (`v1`) at t+2, BLU (`v2`) at t+3.
- Tag exits and FIFO write occur at t+3+`PL_DEPTH`.
- `ds_valid` is first asserted at t+4+`PL_DEPTH`, i.e. 17 cycles after accept with defaults.
- Peak throughput is one pixel per 3 cycles: the next accept can occur in the BLU cycle, giving RED immediately after BLU.
- `ds_data` and `ds_valid` are held stable while `ds_stall`=1.
- Pixels leave in the same order they were accepted.
- `us_stall` is combinational from `us_valid`, FSM state and `credit`. All other outputs are registered.

## Structure
- Shared package holds:
  - Types: `pixelID_t`, `float_color_t`, `color16_t`, `pixstore_to_cc_t`, `pixel_buffer_entry_t`.
  - Constant: `CC_PL_DEPTH` = 13.
- Sub-module: the codebase `fifo` with width `$bits(pixel_buffer_entry_t)` and depth `FIFO_DEPTH`, used as the output buffer.
- The FSM, tag line and credit counter are inline.

## Test plan
- Single pixel:
  - Stimulus: pixelID 0x00A5, `ds_stall`=0; bench returns `pl_color` 0xF81F at the tag exit.
  - Required: `v0`/`v1`/`v2` at t+1/t+2/t+3; `ds_valid` at t+17 with data {0x00A5, 0xF81F} for exactly 1 cycle.
- Streaming: 30 pixels presented back-to-back.
  - Required: accepts every 3 cycles; `us_stall` high for 2 of every 3 cycles; outputs in order with correct IDs.
- Downstream backpressure: `ds_stall`=1 held while streaming.
  - Required: exactly 16 accepts, then `us_stall` stays 1 and no FIFO overflow.
  - After release, 16 in-order outputs, then accepts resume.
- Simultaneous accept and pop at `credit`=1: `credit` stays 1 and the next accept is still allowed.
- Reset mid-flight: `rst` asserted 5 cycles after accepting 3 pixels.
  - Required: all outputs reach reset values, `ds_valid` stays 0 for 40 cycles, and `credit`=16.
- Idle upstream: `us_valid`=0.
  - Required: `us_stall`=0, no strobes, `ds_valid`=0.
